// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential multiplier:
//   - FSM state encodings (plain localparams plus a typed enum built on them)
//   - operand mode encoding
//   - step counter width helper
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    // Raw encodings kept as localparams so older code that compares against
    // bit patterns keeps working; the enum below is built on the same values.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // The step counter is loaded with WIDTH itself, so it needs one value
    // more than WIDTH-1 can express.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// -----------------------------------------------------------------------------
// seq_mult_step
// One combinational multiply iteration over the {acc, q, q_m1} register pair.
//   unsigned : add A when q[0]=1, then logical shift right by one
//   signed   : radix-2 Booth on {q[0], q_m1}, then arithmetic shift right
//
// Ports
//   acc          in   WIDTH+1  running partial product (upper half)
//   q            in   WIDTH    multiplier / low product bits
//   q_m1         in   1        previous q[0] (Booth history bit)
//   a            in   WIDTH    multiplicand
//   signed_mode  in   1        1 = two's-complement, 0 = unsigned
//   acc_next     out  WIDTH+1
//   q_next       out  WIDTH
//   q_m1_next    out  1
// -----------------------------------------------------------------------------
module seq_mult_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH-1:0] a,
    input  logic             signed_mode,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] sum;
    logic           fill;

    always_comb begin
        // Sign-extend A only in signed mode; the extra bit keeps
        // -2^(W-1) * -2^(W-1) from wrapping inside the accumulator.
        a_ext = {(signed_mode & a[WIDTH-1]), a};
        sum   = acc;

        if (signed_mode == MODE_SIGNED) begin
            case ({q[0], q_m1})
                2'b01:   sum = acc + a_ext;
                2'b10:   sum = acc - a_ext;
                default: sum = acc;
            endcase
        end else if (q[0]) begin
            // Unsigned carry lands in sum[WIDTH] and is shifted back down.
            sum = acc + a_ext;
        end

        fill      = (signed_mode == MODE_SIGNED) ? sum[WIDTH] : 1'b0;
        acc_next  = {fill, sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier, one partial-product step
// per clock, unsigned or signed (Booth) selectable per operation.
//
// Ports
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous active-low reset
//   start         in   1        request, taken when not busy
//   signed_mode   in   1        1 = signed, 0 = unsigned (captured with start)
//   multiplicand  in   WIDTH    operand A (captured with start)
//   multiplier    in   WIDTH    operand B (captured with start)
//   busy          out  1        operation in progress
//   done          out  1        one-cycle pulse when result/overflow update
//   overflow      out  1        product does not fit in WIDTH bits
//   result        out  2*WIDTH  full product, held until next completion
//
// State   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for start
// RUN     | one multiply step per cycle, counter counting WIDTH down to 0
// DONE    | product final; result/overflow/done register on this cycle's edge,
//         | a new start is accepted here for back-to-back operation
// -----------------------------------------------------------------------------
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_next;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic             q_m1_q;
    logic [WIDTH-1:0] a_q;
    logic             mode_q;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;
    logic             q_m1_step;

    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     sign_window;
    logic               ovf_calc;

    seq_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc         (acc_q),
        .q           (q_q),
        .q_m1        (q_m1_q),
        .a           (a_q),
        .signed_mode (mode_q),
        .acc_next    (acc_step),
        .q_next      (q_step),
        .q_m1_next   (q_m1_step)
    );

    // After the last step the low WIDTH bits of acc plus q hold the product;
    // acc[WIDTH] is only a guard bit for the Booth add/subtract.
    assign product     = {acc_q[WIDTH-1:0], q_q};
    assign sign_window = product[2*WIDTH-1:WIDTH-1];
    assign cnt_next    = cnt_q - CW'(1);

    always_comb begin
        ovf_calc = 1'b0;
        if (mode_q == MODE_SIGNED) begin
            // Fits as a signed WIDTH-bit value only if the upper half is a
            // pure copy of bit WIDTH-1.
            ovf_calc = !((&sign_window) || !(|sign_window));
        end else begin
            ovf_calc = |product[2*WIDTH-1:WIDTH];
        end
    end

    assign busy = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            a_q     <= '0;
            mode_q  <= MODE_UNSIGNED;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= multiplicand;
                        q_q     <= multiplier;
                        mode_q  <= signed_mode;
                        acc_q   <= '0;
                        q_m1_q  <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q  <= acc_step;
                    q_q    <= q_step;
                    q_m1_q <= q_m1_step;
                    cnt_q  <= cnt_next;
                    if (cnt_next == '0) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs only move on the edge that leaves DONE (or on reset), so a
    // back-to-back start captured on that same edge cannot disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            result   <= '0;
        end else begin
            done <= (state_q == DONE);
            if (state_q == DONE) begin
                result   <= product;
                overflow <= ovf_calc;
            end
        end
    end

endmodule
